// File: rtl/bcd_disp_pkg.sv
// Shared constants for BCD 7-segment display stages.
// Glyphs are active-high in {g,f,e,d,c,b,a} order.
// DIG_UNITS/DIG_TENS index the two-digit shadow register and the anode bus.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  localparam int DIG_UNITS = 0;
  localparam int DIG_TENS  = 1;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, active-high output.
// Codes 10..15 are not valid BCD and are shown as a dash (segment g).
//   bcd : 4-bit code in
//   seg : {g,f,e,d,c,b,a} pattern out
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Two-digit time-multiplexed common-anode 7-segment driver.
// Both digits are captured together at the end of each tens slot so a
// frame never mixes two counter values. Each slot opens with a guard
// window of dark anodes to suppress ghosting. an/seg are registered.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   en    : display enable (timing keeps running while low)
//   bcd1  : tens digit, bcd0 : units digit
//   an    : anode enables, an[0] units, an[1] tens
//   seg   : segments {g,f,e,d,c,b,a}
module bcd_display_mux
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD_CYCLES  = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  output logic [1:0] an,
  output logic [6:0] seg
);

  localparam int              CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]   GUARD   = CW'(GUARD_CYCLES);
  // XOR masks: all-ones flips internal active-high to active-low pins
  localparam logic [1:0]      AN_POL  = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
  localparam logic [6:0]      SEG_POL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [CW-1:0]   cnt;
  logic            digit_sel;
  logic [1:0][3:0] shadow;
  logic            slot_end;
  logic [3:0]      cur_bcd;
  logic [6:0]      glyph;
  logic            blank;
  logic            active;
  logic [1:0]      an_nxt;
  logic [6:0]      seg_nxt;

  assign slot_end = (cnt == CNT_MAX);
  assign cur_bcd  = shadow[digit_sel];

  bcd_to_7seg u_dec (
    .bcd (cur_bcd),
    .seg (glyph)
  );

  always_comb begin
    an_nxt  = 2'b00;
    seg_nxt = SEG_OFF;
    blank   = (BLANK_LEADING != 0) && (digit_sel == 1'(DIG_TENS))
              && (shadow[DIG_TENS] == 4'd0);
    active  = en && (cnt >= GUARD) && !blank;
    if (active) begin
      an_nxt[digit_sel] = 1'b1;
      seg_nxt           = glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      digit_sel <= 1'(DIG_UNITS);
      shadow    <= '0;
      an        <= AN_POL;
      seg       <= SEG_POL;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        digit_sel <= ~digit_sel;
        // latch the next frame only as the tens slot closes
        if (digit_sel == 1'(DIG_TENS)) begin
          shadow[DIG_TENS]  <= bcd1;
          shadow[DIG_UNITS] <= bcd0;
        end
      end
      an  <= an_nxt ^ AN_POL;
      seg <= seg_nxt ^ SEG_POL;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux with REFRESH_DIV=8, GUARD_CYCLES=2,
// active-low outputs and leading-zero blanking. Glyphs below are the
// active-low pin patterns worked out by hand.
module tb_bcd_display_mux;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic [3:0] bcd1 = 4'd4;
  logic [3:0] bcd0 = 4'd2;
  logic [1:0] an;
  logic [6:0] seg;

  int total = 0;
  int bad = 0;

  localparam logic [6:0] L_0 = 7'b1000000;
  localparam logic [6:0] L_1 = 7'b1111001;
  localparam logic [6:0] L_2 = 7'b0100100;
  localparam logic [6:0] L_3 = 7'b0110000;
  localparam logic [6:0] L_4 = 7'b0011001;
  localparam logic [6:0] L_5 = 7'b0010010;
  localparam logic [6:0] L_6 = 7'b0000010;
  localparam logic [6:0] L_7 = 7'b1111000;
  localparam logic [6:0] L_8 = 7'b0000000;
  localparam logic [6:0] L_9 = 7'b0010000;
  localparam logic [6:0] L_D = 7'b0111111;
  localparam logic [6:0] L_X = 7'b1111111;

  bcd_display_mux #(
    .REFRESH_DIV   (8),
    .GUARD_CYCLES  (2),
    .ACTIVE_LOW    (1),
    .BLANK_LEADING (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bcd1  (bcd1),
    .bcd0  (bcd0),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles of one slot starting at its first cycle; inputs may be
  // changed right after cycle chg_k to probe frame coherence.
  task automatic run_slot(input string tag, input bit tens, input bit on,
                          input logic [6:0] g, input int n, input int chg_k,
                          input logic [3:0] nb1, input logic [3:0] nb0);
    logic [1:0] ea;
    logic [6:0] es;
    for (int c = 0; c < n; c++) begin
      tick();
      ea = (c >= 2 && on) ? (tens ? 2'b01 : 2'b10) : 2'b11;
      es = (c >= 2 && on) ? g : L_X;
      chk($sformatf("%s_an%0d", tag, c), 7'(an), 7'(ea));
      chk($sformatf("%s_seg%0d", tag, c), seg, es);
      chk($sformatf("%s_onehot%0d", tag, c), 7'(an != 2'b00), 7'd1);
      if (c == chg_k) begin
        bcd1 = nb1;
        bcd0 = nb0;
      end
    end
  endtask

  initial begin
    // reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_an%0d", i), 7'(an), 7'h03);
      chk($sformatf("rst_seg%0d", i), seg, L_X);
    end
    reset = 1'b0;

    // frame 0: shadow still 00 -> "0" on units, tens blanked; captures 42
    run_slot("f0u", 1'b0, 1'b1, L_0, 8, -1, 4'd0, 4'd0);
    run_slot("f0t", 1'b1, 1'b0, L_X, 8, -1, 4'd0, 4'd0);
    // frame 1 shows 42; load 39 for capture at its end
    bcd1 = 4'd3; bcd0 = 4'd9;
    run_slot("f1u", 1'b0, 1'b1, L_2, 8, -1, 4'd0, 4'd0);
    run_slot("f1t", 1'b1, 1'b1, L_4, 8, -1, 4'd0, 4'd0);
    // frame 2 shows 39; switch to 40 mid tens slot
    run_slot("f2u", 1'b0, 1'b1, L_9, 8, -1, 4'd0, 4'd0);
    run_slot("f2t", 1'b1, 1'b1, L_3, 8, 3, 4'd4, 4'd0);
    // frame 3 shows 40; load 07
    run_slot("f3u", 1'b0, 1'b1, L_0, 8, 0, 4'd0, 4'd7);
    run_slot("f3t", 1'b1, 1'b1, L_4, 8, -1, 4'd0, 4'd0);
    // frame 4 shows 7 with tens blanked; load C5
    run_slot("f4u", 1'b0, 1'b1, L_7, 8, 0, 4'hC, 4'd5);
    run_slot("f4t", 1'b1, 1'b0, L_X, 8, -1, 4'd0, 4'd0);
    // frame 5 shows dash/5
    run_slot("f5u", 1'b0, 1'b1, L_5, 8, -1, 4'd0, 4'd0);
    run_slot("f5t", 1'b1, 1'b1, L_D, 8, -1, 4'd0, 4'd0);
    // frame 6: disable 4 cycles into the tens slot for 20 cycles
    run_slot("f6u", 1'b0, 1'b1, L_5, 8, -1, 4'd0, 4'd0);
    run_slot("f6t", 1'b1, 1'b1, L_D, 4, -1, 4'd0, 4'd0);
    en = 1'b0;
    bcd1 = 4'd6; bcd0 = 4'd1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("en_an%0d", i), 7'(an), 7'h03);
      chk($sformatf("en_seg%0d", i), seg, L_X);
    end
    en = 1'b1;
    // frame 8: phase must be intact, showing 61 captured while disabled
    run_slot("f8u", 1'b0, 1'b1, L_1, 8, -1, 4'd0, 4'd0);
    run_slot("f8t", 1'b1, 1'b1, L_6, 8, -1, 4'd0, 4'd0);
    // frame 9: reset in the middle of the tens slot
    bcd1 = 4'd5; bcd0 = 4'd8;
    run_slot("f9u", 1'b0, 1'b1, L_1, 8, -1, 4'd0, 4'd0);
    run_slot("f9t", 1'b1, 1'b1, L_6, 5, -1, 4'd0, 4'd0);
    reset = 1'b1;
    tick();
    chk("mrst_an", 7'(an), 7'h03);
    chk("mrst_seg", seg, L_X);
    reset = 1'b0;
    // restart from cnt=0 units with shadow 00; first capture 2*8 cycles later
    run_slot("r0u", 1'b0, 1'b1, L_0, 8, -1, 4'd0, 4'd0);
    run_slot("r0t", 1'b1, 1'b0, L_X, 8, -1, 4'd0, 4'd0);
    run_slot("r1u", 1'b0, 1'b1, L_8, 8, -1, 4'd0, 4'd0);
    run_slot("r1t", 1'b1, 1'b1, L_5, 8, -1, 4'd0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
